// File: rtl/wb.sv
// Write-back stage: register-file write port, HI/LO, and the CP0 subset
// (Status, Cause, EPC, BadVAddr, Count) with exception/ERET redirect.
module wb #(
    parameter logic [31:0] EXC_ENTRY  = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         WB_valid,
    input  logic [155:0] MEM_WB_bus_r,
    output logic         rf_wen,
    output logic [4:0]   rf_wdest,
    output logic [31:0]  rf_wdata,
    output logic         WB_over,
    output logic [4:0]   WB_wdest,
    output logic         cancel,
    output logic [31:0]  exc_pc,
    output logic [31:0]  WB_pc
);

    localparam logic [7:0] ADDR_BADVADDR = 8'h40;
    localparam logic [7:0] ADDR_COUNT    = 8'h48;
    localparam logic [7:0] ADDR_STATUS   = 8'h60;
    localparam logic [7:0] ADDR_CAUSE    = 8'h68;
    localparam logic [7:0] ADDR_EPC      = 8'h70;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Bus fields, MSB first.
    logic        bus_rf_wen;
    logic [4:0]  bus_rf_wdest;
    logic [31:0] mem_result;
    logic [31:0] lo_result;
    logic        hi_write;
    logic        lo_write;
    logic        mfhi;
    logic        mflo;
    logic        mtc0;
    logic        mfc0;
    logic [7:0]  cp0r_addr;
    logic        syscall;
    logic        eret;
    logic        brk;
    logic        fetch_error;
    logic        inst_reserved;
    logic        raddr_error;
    logic        waddr_error;
    logic        overflow;
    logic [31:0] dm_addr;
    logic [31:0] pc;

    assign bus_rf_wen    = MEM_WB_bus_r[155];
    assign bus_rf_wdest  = MEM_WB_bus_r[154:150];
    assign mem_result    = MEM_WB_bus_r[149:118];
    assign lo_result     = MEM_WB_bus_r[117:86];
    assign hi_write      = MEM_WB_bus_r[85];
    assign lo_write      = MEM_WB_bus_r[84];
    assign mfhi          = MEM_WB_bus_r[83];
    assign mflo          = MEM_WB_bus_r[82];
    assign mtc0          = MEM_WB_bus_r[81];
    assign mfc0          = MEM_WB_bus_r[80];
    assign cp0r_addr     = MEM_WB_bus_r[79:72];
    assign syscall       = MEM_WB_bus_r[71];
    assign eret          = MEM_WB_bus_r[70];
    assign brk           = MEM_WB_bus_r[69];
    assign fetch_error   = MEM_WB_bus_r[68];
    assign inst_reserved = MEM_WB_bus_r[67];
    assign raddr_error   = MEM_WB_bus_r[66];
    assign waddr_error   = MEM_WB_bus_r[65];
    assign overflow      = MEM_WB_bus_r[64];
    assign dm_addr       = MEM_WB_bus_r[63:32];
    assign pc            = MEM_WB_bus_r[31:0];

    // Architectural state. Status keeps only its writable fields; the rest
    // of the word is the fixed reset pattern.
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic [31:0] count_q, count_d;
    logic        toggle_q, toggle_d;
    logic [7:0]  status_im_q, status_im_d;
    logic        status_exl_q, status_exl_d;
    logic        status_ie_q, status_ie_d;
    logic [1:0]  cause_ip_q, cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;

    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic [31:0] cp0_rdata;

    assign status_rd = {STATUS_RST[31:16], status_im_q, STATUS_RST[7:2],
                        status_exl_q, status_ie_q};
    assign cause_rd  = {22'd0, cause_ip_q, 1'b0, cause_exc_q, 2'b00};

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0r_addr)
            ADDR_BADVADDR: cp0_rdata = badvaddr_q;
            ADDR_COUNT:    cp0_rdata = count_q;
            ADDR_STATUS:   cp0_rdata = status_rd;
            ADDR_CAUSE:    cp0_rdata = cause_rd;
            ADDR_EPC:      cp0_rdata = epc_q;
            default:       cp0_rdata = 32'd0;
        endcase
    end

    // Exception resolution, first match wins.
    logic        exc;
    logic [4:0]  exc_code;
    logic        badv_load;
    logic [31:0] badv_val;

    always_comb begin
        exc       = fetch_error | inst_reserved | overflow | syscall | brk |
                    raddr_error | waddr_error;
        exc_code  = 5'd0;
        badv_load = 1'b0;
        badv_val  = 32'd0;
        if (fetch_error) begin
            exc_code  = EXC_ADEL;
            badv_load = 1'b1;
            badv_val  = pc;
        end else if (inst_reserved) begin
            exc_code = EXC_RI;
        end else if (overflow) begin
            exc_code = EXC_OV;
        end else if (syscall) begin
            exc_code = EXC_SYS;
        end else if (brk) begin
            exc_code = EXC_BP;
        end else if (raddr_error) begin
            exc_code  = EXC_ADEL;
            badv_load = 1'b1;
            badv_val  = dm_addr;
        end else if (waddr_error) begin
            exc_code  = EXC_ADES;
            badv_load = 1'b1;
            badv_val  = dm_addr;
        end
    end

    always_comb begin
        hi_d         = hi_q;
        lo_d         = lo_q;
        epc_d        = epc_q;
        badvaddr_d   = badvaddr_q;
        status_im_d  = status_im_q;
        status_exl_d = status_exl_q;
        status_ie_d  = status_ie_q;
        cause_ip_d   = cause_ip_q;
        cause_exc_d  = cause_exc_q;
        // Count advances every second cycle regardless of WB_valid.
        toggle_d     = ~toggle_q;
        count_d      = toggle_q ? count_q + 32'd1 : count_q;

        if (WB_valid) begin
            if (exc) begin
                cause_exc_d = exc_code;
                if (!status_exl_q) begin
                    epc_d        = pc;
                    status_exl_d = 1'b1;
                end
                if (badv_load) begin
                    badvaddr_d = badv_val;
                end
            end else begin
                if (hi_write) hi_d = mem_result;
                if (lo_write) lo_d = lo_result;
                if (eret) status_exl_d = 1'b0;
                if (mtc0) begin
                    case (cp0r_addr)
                        ADDR_STATUS: begin
                            status_im_d  = mem_result[15:8];
                            status_exl_d = mem_result[1];
                            status_ie_d  = mem_result[0];
                        end
                        ADDR_CAUSE: cause_ip_d = mem_result[9:8];
                        ADDR_EPC:   epc_d      = mem_result;
                        ADDR_COUNT: begin
                            count_d  = mem_result;
                            toggle_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            epc_q        <= 32'd0;
            badvaddr_q   <= 32'd0;
            count_q      <= 32'd0;
            toggle_q     <= 1'b0;
            status_im_q  <= STATUS_RST[15:8];
            status_exl_q <= STATUS_RST[1];
            status_ie_q  <= STATUS_RST[0];
            cause_ip_q   <= 2'd0;
            cause_exc_q  <= 5'd0;
        end else begin
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            epc_q        <= epc_d;
            badvaddr_q   <= badvaddr_d;
            count_q      <= count_d;
            toggle_q     <= toggle_d;
            status_im_q  <= status_im_d;
            status_exl_q <= status_exl_d;
            status_ie_q  <= status_ie_d;
            cause_ip_q   <= cause_ip_d;
            cause_exc_q  <= cause_exc_d;
        end
    end

    logic [31:0] wdata_sel;

    always_comb begin
        if (mfhi)      wdata_sel = hi_q;
        else if (mflo) wdata_sel = lo_q;
        else if (mfc0) wdata_sel = cp0_rdata;
        else           wdata_sel = mem_result;
    end

    // exc_pc uses the pre-edge EPC, so an ERET never sees a same-edge write.
    assign rf_wen   = WB_valid & bus_rf_wen & ~exc;
    assign rf_wdest = WB_valid ? bus_rf_wdest : 5'd0;
    assign rf_wdata = WB_valid ? wdata_sel : 32'd0;
    assign WB_over  = WB_valid;
    assign WB_wdest = WB_valid ? bus_rf_wdest : 5'd0;
    assign cancel   = WB_valid & (exc | eret);
    assign exc_pc   = !WB_valid ? 32'd0 :
                      exc       ? EXC_ENTRY :
                      eret      ? epc_q : 32'd0;
    assign WB_pc    = pc;

endmodule
